// File: rtl/hazard_unit_param.sv
// hazard_unit_param
//   Pipeline hazard controller for a 5-stage MIPS pipeline.
//   - Load-use detection in ID: holds PC and IF/ID for LOAD_STALL cycles and
//     injects bubbles into ID/EX.
//   - Taken branch resolved in EX: flushes IF/ID and ID/EX, aborts any stall.
//   - EX-stage forwarding mux selects (combinational).
//
// Ports
//   clk, rst                 pipeline clock, synchronous active-high reset
//   rs, rt                   source specifiers of the instruction in ID
//   id_ex_memRead            ID/EX holds a load
//   id_ex_rs, id_ex_rt       specifiers in ID/EX (id_ex_rt = load destination)
//   ex_mem_regWrite/_rd      EX/MEM writeback enable and destination
//   mem_wb_regWrite/_rd      MEM/WB writeback enable and destination
//   branch_taken             branch resolved taken in EX
//   control_sel              1 = decoder controls to ID/EX, 0 = bubble
//   if_id_write, pc_write    IF/ID and PC write enables
//   if_id_flush, id_ex_flush clear IF/ID / ID/EX to NOP
//   forward_a, forward_b     00 regfile, 10 EX/MEM, 01 MEM/WB
//
// Optional feature: define HAZARD_PERF_EN to add perf_clr (in),
//   stall_cycles and flush_events (out, PERF_W) saturating counters.
//
// State table
//   state   | meaning
//   S_IDLE  | normal flow; a load-use hazard stalls this cycle
//   S_STALL | remaining stall cycles of a load-use window (r_cnt left)

module hazard_unit_param #(
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_STALL = 1,
   parameter int PERF_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] rt,
   input  logic                  id_ex_memRead,
   input  logic [REG_ADDR_W-1:0] id_ex_rs,
   input  logic [REG_ADDR_W-1:0] id_ex_rt,
   input  logic                  ex_mem_regWrite,
   input  logic [REG_ADDR_W-1:0] ex_mem_rd,
   input  logic                  mem_wb_regWrite,
   input  logic [REG_ADDR_W-1:0] mem_wb_rd,
   input  logic                  branch_taken,
   output logic                  control_sel,
   output logic                  if_id_write,
   output logic                  pc_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b
`ifdef HAZARD_PERF_EN
   ,
   input  logic                  perf_clr,
   output logic [PERF_W-1:0]     stall_cycles,
   output logic [PERF_W-1:0]     flush_events
`endif
);

   if (LOAD_STALL < 1 || LOAD_STALL > 15 || PERF_W < 1) begin : g_param_check
      $error("hazard_unit_param: LOAD_STALL must be 1..15 and PERF_W >= 1");
   end

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_STALL = 1'b1
   } state_t;

   localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       w_hazard;

   assign w_hazard = id_ex_memRead && (id_ex_rt != '0) &&
                     ((id_ex_rt == rs) || (id_ex_rt == rt));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      control_sel = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (rst) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         control_sel = 1'b0;
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = 4'd0;
      end else if (branch_taken) begin
         // The flushed instruction no longer needs its stall window.
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         control_sel = 1'b0;
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hazard) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  control_sel = 1'b0;
                  // The detection cycle is the first of LOAD_STALL stall cycles.
                  if (LOAD_STALL > 1) begin
                     w_state_nxt = S_STALL;
                     w_cnt_nxt   = STALL_RELOAD;
                  end
               end
            end
            S_STALL: begin
               // hazard is not re-evaluated here: the load has left ID/EX.
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               control_sel = 1'b0;
               if (r_cnt <= 4'd1) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = 4'd0;
               end else begin
                  w_cnt_nxt = r_cnt - 4'd1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   // EX/MEM holds the younger result, so it wins over MEM/WB.
   always_comb begin
      forward_a = 2'b00;
      forward_b = 2'b00;
      if (!rst) begin
         if (ex_mem_regWrite && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rs))
            forward_a = 2'b10;
         else if (mem_wb_regWrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rs))
            forward_a = 2'b01;
         if (ex_mem_regWrite && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rt))
            forward_b = 2'b10;
         else if (mem_wb_regWrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rt))
            forward_b = 2'b01;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] r_stall_cycles;
   logic [PERF_W-1:0] r_flush_events;

   always_ff @(posedge clk) begin
      if (rst || perf_clr) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if (!pc_write && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
         if (branch_taken && (r_flush_events != '1))
            r_flush_events <= r_flush_events + PERF_W'(1);
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_unit_param.sv
module tb_hazard_unit_param;

   localparam int AW = 5;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs, rt, id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd;
   logic          id_ex_memRead, ex_mem_regWrite, mem_wb_regWrite, branch_taken;
   logic          perf_clr;

   logic          cs1, ifw1, pcw1, iff1, idf1;
   logic          cs3, ifw3, pcw3, iff3, idf3;
   logic [1:0]    fa1, fb1, fa3, fb3;
`ifdef HAZARD_PERF_EN
   logic [PW-1:0] sc1, fe1, sc3, fe3;
`endif

   always #5 clk = ~clk;

   hazard_unit_param #(.REG_ADDR_W(AW), .LOAD_STALL(1), .PERF_W(PW)) dut1 (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt),
      .id_ex_memRead(id_ex_memRead), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
      .ex_mem_regWrite(ex_mem_regWrite), .ex_mem_rd(ex_mem_rd),
      .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_rd(mem_wb_rd),
      .branch_taken(branch_taken),
      .control_sel(cs1), .if_id_write(ifw1), .pc_write(pcw1),
      .if_id_flush(iff1), .id_ex_flush(idf1),
      .forward_a(fa1), .forward_b(fb1)
`ifdef HAZARD_PERF_EN
      , .perf_clr(perf_clr), .stall_cycles(sc1), .flush_events(fe1)
`endif
   );

   hazard_unit_param #(.REG_ADDR_W(AW), .LOAD_STALL(3), .PERF_W(PW)) dut3 (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt),
      .id_ex_memRead(id_ex_memRead), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
      .ex_mem_regWrite(ex_mem_regWrite), .ex_mem_rd(ex_mem_rd),
      .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_rd(mem_wb_rd),
      .branch_taken(branch_taken),
      .control_sel(cs3), .if_id_write(ifw3), .pc_write(pcw3),
      .if_id_flush(iff3), .id_ex_flush(idf3),
      .forward_a(fa3), .forward_b(fb3)
`ifdef HAZARD_PERF_EN
      , .perf_clr(perf_clr), .stall_cycles(sc3), .flush_events(fe3)
`endif
   );

   // Control outputs packed as {pc_write, if_id_write, control_sel, if_id_flush, id_ex_flush}
   localparam logic [4:0] RUN = 5'b11100;
   localparam logic [4:0] STL = 5'b00000;
   localparam logic [4:0] FLU = 5'b11011;
   localparam logic [4:0] RZ  = 5'b00000;

   typedef struct {
      string      nm;
      logic [4:0] e1;
      logic [4:0] e3;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   wire [4:0] a1 = {pcw1, ifw1, cs1, iff1, idf1};
   wire [4:0] a3 = {pcw3, ifw3, cs3, iff3, idf3};

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_vec++;
         if (a1 !== e.e1 || a3 !== e.e3 || fa1 !== e.fa || fb1 !== e.fb ||
             fa3 !== e.fa || fb3 !== e.fb) begin
            n_bad++;
            $display("FAIL %s: got L1=%b L3=%b fa=%b/%b fb=%b/%b, want L1=%b L3=%b fa=%b fb=%b",
                     e.nm, a1, a3, fa1, fa3, fb1, fb3, e.e1, e.e3, e.fa, e.fb);
         end
      end
   end

   task automatic vec(input string nm, input logic r, input logic mr,
                      input logic [AW-1:0] ers, input logic [AW-1:0] ert,
                      input logic [AW-1:0] rs_i, input logic [AW-1:0] rt_i,
                      input logic exw, input logic [AW-1:0] exrd,
                      input logic wbw, input logic [AW-1:0] wbrd, input logic br,
                      input logic [4:0] e1, input logic [4:0] e3,
                      input logic [1:0] efa, input logic [1:0] efb);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; id_ex_memRead = mr; id_ex_rs = ers; id_ex_rt = ert;
      rs = rs_i; rt = rt_i; ex_mem_regWrite = exw; ex_mem_rd = exrd;
      mem_wb_regWrite = wbw; mem_wb_rd = wbrd; branch_taken = br;
      e.nm = nm; e.e1 = e1; e.e3 = e3; e.fa = efa; e.fb = efb;
      q.push_back(e);
   endtask

`ifdef HAZARD_PERF_EN
   task automatic drv(input logic clr, input logic mr, input logic br);
      @(posedge clk);
      #1;
      rst = 1'b0; perf_clr = clr; id_ex_memRead = mr; id_ex_rt = 5'd5; rs = 5'd5;
      rt = 5'd0; id_ex_rs = 5'd0; ex_mem_regWrite = 1'b0; mem_wb_regWrite = 1'b0;
      branch_taken = br;
   endtask

   task automatic chk_perf(input string nm, input logic [PW-1:0] esc, input logic [PW-1:0] efe);
      n_vec++;
      if (sc3 !== esc || fe3 !== efe) begin
         n_bad++;
         $display("FAIL %s: got stall_cycles=%0d flush_events=%0d, want %0d %0d",
                  nm, sc3, fe3, esc, efe);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; perf_clr = 1'b0; id_ex_memRead = 1'b0; branch_taken = 1'b0;
      rs = '0; rt = '0; id_ex_rs = '0; id_ex_rt = '0;
      ex_mem_regWrite = 1'b0; ex_mem_rd = '0; mem_wb_regWrite = 1'b0; mem_wb_rd = '0;

      //   name           r  mr ers ert rs rt exw exrd wbw wbrd br  L1   L3   fa     fb
      vec("rst_hold",    1, 1, 7,  5,  5, 0, 1,  7,   0,  0,   0, RZ,  RZ,  2'b00, 2'b00);
      vec("rst_2",       1, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RZ,  RZ,  2'b00, 2'b00);
      vec("idle_run",    0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, RUN, 2'b00, 2'b00);
      vec("ld_use_rs",   0, 1, 0,  5,  5, 0, 0,  0,   0,  0,   0, STL, STL, 2'b00, 2'b00);
      vec("stall_2",     0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, STL, 2'b00, 2'b00);
      vec("stall_3",     0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, STL, 2'b00, 2'b00);
      vec("post_stall",  0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, RUN, 2'b00, 2'b00);
      vec("r0_nohaz",    0, 1, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, RUN, 2'b00, 2'b00);
      vec("ld_use_rt",   0, 1, 0,  9,  3, 9, 0,  0,   0,  0,   0, STL, STL, 2'b00, 2'b00);
      vec("br_abort",    0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   1, FLU, FLU, 2'b00, 2'b00);
      vec("post_br",     0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, RUN, 2'b00, 2'b00);
      vec("held_1",      0, 1, 0,  5,  5, 0, 0,  0,   0,  0,   0, STL, STL, 2'b00, 2'b00);
      vec("held_2",      0, 1, 0,  5,  5, 0, 0,  0,   0,  0,   0, STL, STL, 2'b00, 2'b00);
      vec("held_3",      0, 1, 0,  5,  5, 0, 0,  0,   0,  0,   0, STL, STL, 2'b00, 2'b00);
      vec("held_new",    0, 1, 0,  5,  5, 0, 0,  0,   0,  0,   0, STL, STL, 2'b00, 2'b00);
      vec("held_end1",   0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, STL, 2'b00, 2'b00);
      vec("held_end2",   0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, STL, 2'b00, 2'b00);
      vec("held_done",   0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, RUN, 2'b00, 2'b00);
      vec("br_haz",      0, 1, 0,  5,  5, 0, 0,  0,   0,  0,   1, FLU, FLU, 2'b00, 2'b00);
      vec("br_haz_next", 0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, RUN, 2'b00, 2'b00);
      vec("fwd_ex",      0, 0, 7,  3,  0, 0, 1,  7,   1,  7,   0, RUN, RUN, 2'b10, 2'b00);
      vec("fwd_wb",      0, 0, 7,  3,  0, 0, 0,  7,   1,  7,   0, RUN, RUN, 2'b01, 2'b00);
      vec("fwd_r0",      0, 0, 0,  0,  0, 0, 1,  0,   1,  0,   0, RUN, RUN, 2'b00, 2'b00);
      vec("fwd_b",       0, 0, 6,  4,  0, 0, 1,  4,   1,  6,   0, RUN, RUN, 2'b01, 2'b10);
      vec("fwd_stall",   0, 1, 6,  4,  4, 0, 1,  4,   1,  6,   0, STL, STL, 2'b01, 2'b10);
      vec("fwd_st2",     0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, STL, 2'b00, 2'b00);
      vec("fwd_st3",     0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, STL, 2'b00, 2'b00);
      vec("pre_rst_haz", 0, 1, 0,  5,  5, 0, 0,  0,   0,  0,   0, STL, STL, 2'b00, 2'b00);
      vec("rst_abort",   1, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RZ,  RZ,  2'b00, 2'b00);
      vec("after_rst",   0, 0, 0,  0,  0, 0, 0,  0,   0,  0,   0, RUN, RUN, 2'b00, 2'b00);
      vec("fwd_ex_wins", 0, 0, 8,  8,  0, 0, 1,  8,   1,  8,   0, RUN, RUN, 2'b10, 2'b10);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
      end

`ifdef HAZARD_PERF_EN
      drv(1, 0, 0);
      drv(0, 1, 0);
      drv(0, 0, 0);
      drv(0, 0, 0);
      drv(0, 0, 1);
      drv(0, 0, 0);
      chk_perf("perf_count", 4'd3, 4'd1);
      drv(1, 0, 1);
      drv(0, 0, 0);
      chk_perf("perf_clr", 4'd0, 4'd0);
      for (int i = 0; i < 6; i++) begin
         drv(0, 1, 0);
         drv(0, 0, 0);
         drv(0, 0, 0);
      end
      for (int i = 0; i < 16; i++) drv(0, 0, 1);
      drv(0, 0, 0);
      chk_perf("perf_sat", 4'hF, 4'hF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
